mdr_mem_ctrl: RTL and testbench
===============================

# mdr_mem_ctrl

Sequencer for the memory-side datapath: it accepts single read or write requests from the CPU control unit and drives the MAR load strobe, the MDR enable and read-select, and the memory read/write strobes. It waits on a memory-ready handshake, with a bounded wait. It sits between the control unit and the MAR/MDR/memory trio, so the control unit only issues one request and waits for `done`.

## Interface
- `TIMEOUT_CYCLES`, 15: maximum memory-wait cycles before abort; legal range 1..2^CNT_WIDTH.
- `CNT_WIDTH`, 4: width of the wait counter.

- `clock` in 1: single clock; all state updates on its rising edge.
- `clear` in 1: synchronous, active-high reset.
- `rd_req` in 1: request a memory read into the MDR; sampled only in IDLE.
- `wr_req` in 1: request a memory write of BusMuxOut; sampled only in IDLE.
- `mem_ready` in 1: memory completion handshake; sampled only in RD_WAIT and WR_WAIT.
- `mar_enable` out 1: MAR load strobe.
- `mdr_enable` out 1: MDR enable.
- `mdr_read` out 1: MDR source select; 1 = Mdatain, 0 = BusMuxOut.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `timeout_err` out 1: one-cycle pulse on wait-limit abort.

## Operation
- States: IDLE, RD_ADDR, RD_WAIT, WR_ADDR, WR_WAIT, DONE, ERR. Encoding is free.
- Outputs are decoded from state. The only exception is `mdr_enable`/`mdr_read` in RD_WAIT, which also depends on `mem_ready`.
- IDLE: all outputs 0.
  - `rd_req`=1 → RD_ADDR.
  - else `wr_req`=1 → WR_ADDR.
  - Both high → read wins; `wr_req` must stay high to be served later.
- RD_ADDR (1 cycle): `mar_enable`=1 → RD_WAIT.
- RD_WAIT: `mem_read`=1.
  - If `mem_ready`=1: `mdr_enable`=1 and `mdr_read`=1 in the same cycle, so the MDR captures Mdatain on that edge → DONE.
- WR_ADDR (1 cycle): `mar_enable`=1, `mdr_enable`=1, `mdr_read`=0 (MDR loads BusMuxOut) → WR_WAIT.
- WR_WAIT: `mem_write`=1; `mem_ready`=1 → DONE. The MDR is never enabled in WR_WAIT.
- DONE (1 cycle): `done`=1 → IDLE.
- ERR (1 cycle): `timeout_err`=1, memory strobes 0, MDR not enabled → IDLE.
- Wait counter:
  - Cleared to 0 on entry to RD_WAIT or WR_WAIT.
  - Increments on each wait cycle with `mem_ready`=0.
  - If `mem_ready`=0 while count = TIMEOUT_CYCLES-1 → ERR. A wait therefore lasts at most TIMEOUT_CYCLES cycles.
  - `mem_ready`=1 in the final allowed cycle completes normally; ready has priority over timeout.
- Requests arriving while `busy`=1 are ignored, not queued.

## Timing
- Reset: `clear`=1 at an edge → state IDLE, counter 0, all outputs 0 from the next cycle. This holds from any state, including mid-wait; an aborted op produces no `done` and no `timeout_err`.
- Read latency, request sampled at edge k with `mem_ready` already high:
  - RD_ADDR in cycle k+1.
  - RD_WAIT in k+2; MDR loads at the end of k+2.
  - `done` in k+3.
  - `busy` high in cycles k+1..k+3.
- Write latency: identical shape. The MAR and MDR both load at the end of cycle k+1, and `done` is in k+3.
- Each extra cycle of `mem_ready`=0 adds one cycle. The minimum back-to-back rate is one op per 4 cycles (the IDLE cycle is included).
- `done` and `timeout_err` are never high together, and each is high for exactly one cycle.

## Test plan
- Read, `mem_ready` tied 1, `rd_req` pulsed at edge 0:
  - `mar_enable` in cycle 1.
  - `mem_read`, `mdr_enable` and `mdr_read` in cycle 2.
  - `done` in cycle 3.
  - MDR holds the Mdatain value (e.g. 0xDEADBEEF).
- Write with `mem_ready` raised after 3 wait cycles:
  - `mar_enable`, `mdr_enable` and `mdr_read`=0 in cycle 1.
  - `mem_write` in cycles 2–5.
  - `done` in cycle 6.
- Timeout, TIMEOUT_CYCLES=4, `mem_ready`=0:
  - `mem_read` for exactly 4 cycles.
  - `timeout_err` pulse, no `done`, MDR never enabled.
  - Repeat with `mem_ready` rising on the 4th wait cycle → `done`, no error.
- `rd_req` and `wr_req` high together and held:
  - Read served first, then the write starts from the next IDLE.
  - A request pulsed during `busy` is dropped.
- `clear` asserted in RD_WAIT at wait cycle 2:
  - Next cycle all outputs 0 and `busy`=0, with no `done` or `timeout_err`.
  - A subsequent read completes with normal latency.

Source files
------------

// File: rtl/mdr_mem_ctrl.sv
// mdr_mem_ctrl: memory-side sequencer between the CPU control unit and the
// MAR/MDR/memory trio. Takes one read or write request at a time, strobes the
// MAR and MDR, drives the memory read/write strobes and waits on mem_ready
// for at most TIMEOUT_CYCLES cycles before aborting with timeout_err.
//
// Ports:
//   i_clock        clock, all state updates on the rising edge
//   i_clear        synchronous active-high reset
//   i_rd_req       read request (sampled only in IDLE, wins over i_wr_req)
//   i_wr_req       write request (sampled only in IDLE)
//   i_mem_ready    memory completion handshake (sampled only while waiting)
//   o_mar_enable   MAR load strobe
//   o_mdr_enable   MDR enable
//   o_mdr_read     MDR source select, 1 = Mdatain, 0 = BusMuxOut
//   o_mem_read     memory read strobe
//   o_mem_write    memory write strobe
//   o_busy         high whenever the sequencer is not idle
//   o_done         one-cycle pulse on successful completion
//   o_timeout_err  one-cycle pulse on wait-limit abort
module mdr_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_WIDTH      = 4
) (
  input  logic i_clock,
  input  logic i_clear,
  input  logic i_rd_req,
  input  logic i_wr_req,
  input  logic i_mem_ready,
  output logic o_mar_enable,
  output logic o_mdr_enable,
  output logic o_mdr_read,
  output logic o_mem_read,
  output logic o_mem_write,
  output logic o_busy,
  output logic o_done,
  output logic o_timeout_err
);

  // Count value of the last allowed wait cycle; TIMEOUT_CYCLES may equal
  // 2^CNT_WIDTH, so the limit is held as count-1 to stay within CNT_WIDTH.
  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  // State and wait-counter registers.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and output decode. Outputs are decoded from state, except the
  // MDR capture in RD_WAIT, which follows mem_ready in the same cycle so the
  // MDR latches Mdatain on the completing edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    o_mar_enable  = 1'b0;
    o_mdr_enable  = 1'b0;
    o_mdr_read    = 1'b0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_busy        = (r_state != ST_IDLE);
    o_done        = 1'b0;
    o_timeout_err = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_rd_req) begin
          w_state_nxt = ST_RD_ADDR;
        end else if (i_wr_req) begin
          w_state_nxt = ST_WR_ADDR;
        end
      end

      ST_RD_ADDR: begin
        o_mar_enable = 1'b1;
        w_cnt_nxt    = '0;
        w_state_nxt  = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        o_mem_read = 1'b1;
        if (i_mem_ready) begin
          o_mdr_enable = 1'b1;
          o_mdr_read   = 1'b1;
          w_state_nxt  = ST_DONE;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end

      ST_WR_ADDR: begin
        // MAR takes the address and MDR takes BusMuxOut on the same edge.
        o_mar_enable = 1'b1;
        o_mdr_enable = 1'b1;
        w_cnt_nxt    = '0;
        w_state_nxt  = ST_WR_WAIT;
      end

      ST_WR_WAIT: begin
        o_mem_write = 1'b1;
        if (i_mem_ready) begin
          w_state_nxt = ST_DONE;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end

      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      ST_ERR: begin
        o_timeout_err = 1'b1;
        w_state_nxt   = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Bench for mdr_mem_ctrl: the driver issues whole operations and pushes the
// predicted outcome of each (derived from request cycle, ready delay and the
// wait limit) into a scoreboard; a monitor accumulates strobe activity per
// operation and checks it against the popped prediction on done/timeout_err.
module tb_mdr_mem_ctrl;

  localparam int unsigned T  = 4;
  localparam int unsigned CW = 2;

  typedef struct {
    bit          is_wr;
    bit          ok;
    int          k;
    int          d;
    int          end_c;
    int          strobes;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic clear, rd, wr, ready;
  logic mar, mdr_en, mdr_rd, mem_rd, mem_wr, busy, done, terr;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  bit   mon_en = 1'b0;

  logic [31:0] mdatain, busmux, mdr_q;
  exp_t        sb[$];

  mdr_mem_ctrl #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)) dut (
    .i_clock      (clk),
    .i_clear      (clear),
    .i_rd_req     (rd),
    .i_wr_req     (wr),
    .i_mem_ready  (ready),
    .o_mar_enable (mar),
    .o_mdr_enable (mdr_en),
    .o_mdr_read   (mdr_rd),
    .o_mem_read   (mem_rd),
    .o_mem_write  (mem_wr),
    .o_busy       (busy),
    .o_done       (done),
    .o_timeout_err(terr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // MDR register of the surrounding datapath.
  always @(posedge clk) if (mdr_en) mdr_q <= mdr_rd ? mdatain : busmux;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One operation: request in cycle k, mem_ready low for d wait cycles and
  // high afterwards; 'both' raises wr_req alongside rd_req and keeps it high.
  task automatic run_op(input bit is_wr, input int d, input bit both);
    exp_t e;
    int   k, s;
    bit   stray_rd;
    k         = cyc;
    mdatain   = $urandom;
    busmux    = $urandom;
    e.is_wr   = is_wr;
    e.ok      = (d < int'(T));
    e.k       = k;
    e.d       = d;
    e.end_c   = e.ok ? k + 3 + d : k + 2 + int'(T);
    e.strobes = e.ok ? d + 1 : int'(T);
    e.data    = is_wr ? busmux : mdatain;
    sb.push_back(e);
    n_pushed++;
    s        = k + 1 + int'($urandom_range(0, e.end_c - k - 1));
    stray_rd = both ? 1'b1 : 1'($urandom_range(0, 1));
    for (int c = k; c <= e.end_c; c++) begin
      if (c != k) next_cycle();
      if (c == k) begin
        rd = !is_wr;
        wr = is_wr | both;
      end else begin
        rd = (c == s) && stray_rd;
        wr = both | ((c == s) && !stray_rd);
      end
      ready = (c < k + 2) ? 1'($urandom_range(0, 1)) : ((c - (k + 2)) >= d);
    end
    next_cycle();
    rd    = 1'b0;
    wr    = both;
    ready = 1'b0;
  endtask

  // Read aborted by clear during its second wait cycle.
  task automatic clear_op();
    rd    = 1'b1;
    ready = 1'b0;
    next_cycle();
    rd = 1'b0;
    next_cycle();
    next_cycle();
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    chk("clear_busy", longint'(busy), 0);
    chk("clear_outputs", longint'({mar, mdr_en, mdr_rd, mem_rd, mem_wr, done, terr}), 0);
  endtask

  // Monitor: per-operation activity accumulated until done/timeout_err.
  int   a_mar, a_mar_cyc, a_mdr, a_mdr_cyc, a_mdr_sel, a_rd, a_wr, a_busy;
  exp_t m_e;

  task automatic acc_reset();
    a_mar = 0; a_mar_cyc = -1; a_mdr = 0; a_mdr_cyc = -1; a_mdr_sel = 0;
    a_rd = 0; a_wr = 0; a_busy = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (!busy) chk("idle_outputs", longint'({mar, mdr_en, mdr_rd, mem_rd, mem_wr, done, terr}), 0);
      if (done || terr) chk("done_err_exclusive", longint'(done && terr), 0);
      if (mar) begin a_mar++; a_mar_cyc = cyc; end
      if (mdr_en) begin a_mdr++; a_mdr_cyc = cyc; a_mdr_sel = int'(mdr_rd); end
      if (mem_rd) a_rd++;
      if (mem_wr) a_wr++;
      if (busy) a_busy++;
      if (done || terr) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion at cycle %0d: got done=%0d err=%0d expected none", cyc, done, terr);
        end else begin
          m_e = sb.pop_front();
          n_popped++;
          chk("outcome_done", longint'(done), longint'(m_e.ok));
          chk("end_cycle", cyc, m_e.end_c);
          chk("mar_count", a_mar, 1);
          chk("mar_cycle", a_mar_cyc, m_e.k + 1);
          chk("mdr_count", a_mdr, (m_e.is_wr || m_e.ok) ? 1 : 0);
          if (m_e.is_wr || m_e.ok) begin
            chk("mdr_cycle", a_mdr_cyc, m_e.is_wr ? m_e.k + 1 : m_e.k + 2 + m_e.d);
            chk("mdr_select", a_mdr_sel, m_e.is_wr ? 0 : 1);
          end
          chk("mem_read_cycles", a_rd, m_e.is_wr ? 0 : m_e.strobes);
          chk("mem_write_cycles", a_wr, m_e.is_wr ? m_e.strobes : 0);
          chk("busy_cycles", a_busy, m_e.end_c - m_e.k);
          if (m_e.ok) chk("mdr_data", longint'(mdr_q), longint'(m_e.data));
        end
        acc_reset();
      end
      if (clear) acc_reset();
    end
  end

  initial begin
    int  g, d;
    bit  w, both;
    clear = 1'b1;
    rd    = 1'b0;
    wr    = 1'b0;
    ready = 1'b0;
    mdatain = '0;
    busmux  = '0;
    mdr_q   = '0;
    acc_reset();
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b0;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_outputs", longint'({mar, mdr_en, mdr_rd, mem_rd, mem_wr, done, terr}), 0);
    mon_en = 1'b1;
    next_cycle();

    run_op(1'b0, 0, 1'b0);          // read, ready tied high
    mdatain = 32'hDEADBEEF;
    run_op(1'b1, 3, 1'b0);          // write, ready after 3 wait cycles
    run_op(1'b0, 4, 1'b0);          // read times out
    run_op(1'b1, 5, 1'b0);          // write times out
    run_op(1'b0, 3, 1'b0);          // ready on the final allowed cycle
    run_op(1'b0, 1, 1'b1);          // both requests: read first ...
    run_op(1'b1, 0, 1'b0);          // ... then the held write
    next_cycle();
    clear_op();
    run_op(1'b0, 0, 1'b0);          // normal read after clear

    for (int i = 0; i < 150; i++) begin
      both = ($urandom_range(0, 7) == 0);
      w    = 1'($urandom_range(0, 1));
      d    = int'($urandom_range(0, 6));
      if (both) begin
        run_op(1'b0, d, 1'b1);
        run_op(1'b1, int'($urandom_range(0, 6)), 1'b0);
      end else begin
        run_op(w, d, 1'b0);
      end
      g = int'($urandom_range(0, 2));
      repeat (g) next_cycle();
    end

    repeat (4) next_cycle();
    chk("scoreboard_empty", sb.size(), 0);
    chk("ops_completed", n_popped, n_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
